// File: rtl/cover_scan_sched.sv
// Raster-scan scheduler for the two-circle laser coverage flow: walks a window
// of candidate centres, counts covered points per centre and keeps the first best.
module cover_scan_sched #(
  parameter int NPTS = 40,
  parameter int R2   = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [3:0] i_win_x0,
  input  logic [3:0] i_win_y0,
  input  logic [3:0] i_win_x1,
  input  logic [3:0] i_win_y1,
  input  logic       i_mode,
  input  logic [3:0] i_fix_x,
  input  logic [3:0] i_fix_y,
  output logic [5:0] o_pt_idx,
  input  logic [3:0] i_pt_x,
  input  logic [3:0] i_pt_y,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_best_x,
  output logic [3:0] o_best_y,
  output logic [5:0] o_best_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_CMP   = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  localparam logic [5:0] LAST_IDX = 6'(NPTS - 1);
  localparam logic [8:0] R2_LIM   = 9'(R2);

  logic [2:0] r_state;

  logic [3:0] r_x0;
  logic [3:0] r_y0;
  logic [3:0] r_x1;
  logic [3:0] r_y1;
  logic       r_mode;
  logic [3:0] r_fix_x;
  logic [3:0] r_fix_y;

  logic [3:0] r_cx;
  logic [3:0] r_cy;
  logic [5:0] r_idx;
  logic [5:0] r_acc;
  logic       r_eval;

  logic [3:0] r_best_x;
  logic [3:0] r_best_y;
  logic [5:0] r_best_cnt;

  logic       w_hit_cand;
  logic       w_hit_fix;
  logic       w_covered;
  logic       w_last_cand;
  logic       w_row_end;

  // Squared distance fits in 9 bits (max 2*15^2 = 450), so no overflow in the compare.
  function automatic logic f_in_circle(
    input logic [3:0] px,
    input logic [3:0] py,
    input logic [3:0] cx,
    input logic [3:0] cy
  );
    logic [3:0] dx;
    logic [3:0] dy;
    logic [7:0] dx2;
    logic [7:0] dy2;
    logic [8:0] dist2;
    dx    = (px >= cx) ? (px - cx) : (cx - px);
    dy    = (py >= cy) ? (py - cy) : (cy - py);
    dx2   = {4'd0, dx} * {4'd0, dx};
    dy2   = {4'd0, dy} * {4'd0, dy};
    dist2 = {1'b0, dx2} + {1'b0, dy2};
    return (dist2 <= R2_LIM);
  endfunction

  always_comb begin
    w_hit_cand  = f_in_circle(i_pt_x, i_pt_y, r_cx, r_cy);
    w_hit_fix   = f_in_circle(i_pt_x, i_pt_y, r_fix_x, r_fix_y);
    w_covered   = w_hit_cand | (r_mode & w_hit_fix);
    w_row_end   = (r_cx == r_x1);
    w_last_cand = w_row_end && (r_cy == r_y1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) r_state <= S_INIT;
        S_INIT:  r_state <= S_SCAN;
        S_SCAN:  if (r_idx == LAST_IDX) r_state <= S_DRAIN;
        S_DRAIN: r_state <= S_CMP;
        S_CMP:   r_state <= w_last_cand ? S_FIN : S_SCAN;
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Job parameters; an inverted window collapses to its start row/column in INIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x0    <= 4'd0;
      r_y0    <= 4'd0;
      r_x1    <= 4'd0;
      r_y1    <= 4'd0;
      r_mode  <= 1'b0;
      r_fix_x <= 4'd0;
      r_fix_y <= 4'd0;
    end else if (r_state == S_IDLE && i_start) begin
      r_x0    <= i_win_x0;
      r_y0    <= i_win_y0;
      r_x1    <= i_win_x1;
      r_y1    <= i_win_y1;
      r_mode  <= i_mode;
      r_fix_x <= i_fix_x;
      r_fix_y <= i_fix_y;
    end else if (r_state == S_INIT) begin
      if (r_x1 < r_x0) r_x1 <= r_x0;
      if (r_y1 < r_y0) r_y1 <= r_y0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cx <= 4'd0;
      r_cy <= 4'd0;
    end else if (r_state == S_INIT) begin
      r_cx <= r_x0;
      r_cy <= r_y0;
    end else if (r_state == S_CMP && !w_last_cand) begin
      if (w_row_end) begin
        r_cx <= r_x0;
        r_cy <= r_cy + 4'd1;
      end else begin
        r_cx <= r_cx + 4'd1;
      end
    end
  end

  // r_eval marks the cycle in which the point issued last cycle is on i_pt_x/i_pt_y.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx  <= 6'd0;
      r_acc  <= 6'd0;
      r_eval <= 1'b0;
    end else begin
      r_eval <= (r_state == S_SCAN);
      case (r_state)
        S_INIT, S_CMP: begin
          r_idx <= 6'd0;
          r_acc <= 6'd0;
        end
        S_SCAN: begin
          r_idx <= r_idx + 6'd1;
          if (r_eval && w_covered) r_acc <= r_acc + 6'd1;
        end
        S_DRAIN: begin
          if (r_eval && w_covered) r_acc <= r_acc + 6'd1;
        end
        default: begin
          r_idx <= r_idx;
          r_acc <= r_acc;
        end
      endcase
    end
  end

  // Strict greater-than keeps the earliest raster-order centre on ties.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_best_x   <= 4'd0;
      r_best_y   <= 4'd0;
      r_best_cnt <= 6'd0;
    end else if (r_state == S_INIT) begin
      r_best_x   <= r_x0;
      r_best_y   <= r_y0;
      r_best_cnt <= 6'd0;
    end else if (r_state == S_CMP && r_acc > r_best_cnt) begin
      r_best_x   <= r_cx;
      r_best_y   <= r_cy;
      r_best_cnt <= r_acc;
    end
  end

  always_comb begin
    o_pt_idx   = (r_state == S_SCAN) ? r_idx : 6'd0;
    o_busy     = (r_state == S_INIT) || (r_state == S_SCAN) ||
                 (r_state == S_DRAIN) || (r_state == S_CMP);
    o_done     = (r_state == S_FIN);
    o_best_x   = r_best_x;
    o_best_y   = r_best_y;
    o_best_cnt = r_best_cnt;
  end

endmodule

// File: tb/tb_cover_scan_sched.sv
// Scoreboard bench for cover_scan_sched: directed jobs push expected results,
// a negedge monitor pops and compares whenever DONE is presented.
module tb_cover_scan_sched;

  localparam int NPTS = 40;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [5:0] cnt;
    int         lat;
    int         startCycle;
  } expT;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic [3:0] winX0, winY0, winX1, winY1;
  logic       mode;
  logic [3:0] fixX, fixY;
  logic [5:0] ptIdx;
  logic [3:0] ptX, ptY;
  logic       busy, done;
  logic [3:0] bestX, bestY;
  logic [5:0] bestCnt;

  logic [3:0] memX [64];
  logic [3:0] memY [64];

  expT expQ[$];
  int  checks = 0;
  int  fails = 0;
  int  cycleCnt = 0;
  int  doneCount = 0;
  int  doneMark = 0;
  int  busyCycles = 0;

  cover_scan_sched #(.NPTS(NPTS), .R2(16)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start),
    .i_win_x0(winX0), .i_win_y0(winY0), .i_win_x1(winX1), .i_win_y1(winY1),
    .i_mode(mode), .i_fix_x(fixX), .i_fix_y(fixY),
    .o_pt_idx(ptIdx), .i_pt_x(ptX), .i_pt_y(ptY),
    .o_busy(busy), .o_done(done),
    .o_best_x(bestX), .o_best_y(bestY), .o_best_cnt(bestCnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Registered point memory: data appears the cycle after the index.
  always @(posedge clk) begin
    ptX <= memX[ptIdx];
    ptY <= memY[ptIdx];
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    expT e;
    if (!rstN) begin
      busyCycles = 0;
    end else begin
      if (busy) busyCycles++;
      if (done) begin
        doneCount++;
        checkOutput("done_busy_exclusive", int'(busy), 0);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", doneCount, doneMark);
        end else begin
          e = expQ.pop_front();
          checkOutput("best_x", bestX, e.x);
          checkOutput("best_y", bestY, e.y);
          checkOutput("best_cnt", bestCnt, e.cnt);
          checkOutput("done_latency", cycleCnt - e.startCycle, e.lat);
          checkOutput("busy_cycles", busyCycles, e.lat - 1);
        end
        busyCycles = 0;
      end
    end
  end

  task automatic fillPoints(input logic [3:0] x, input logic [3:0] y);
    for (int i = 0; i < 64; i++) begin
      memX[i] = x;
      memY[i] = y;
    end
  endtask

  task automatic fillSplit(input logic [3:0] xa, input logic [3:0] ya,
                           input logic [3:0] xb, input logic [3:0] yb);
    for (int i = 0; i < 64; i++) begin
      memX[i] = (i < 20) ? xa : xb;
      memY[i] = (i < 20) ? ya : yb;
    end
  endtask

  task automatic applyStimulus(
    input logic [3:0] wx0, input logic [3:0] wy0,
    input logic [3:0] wx1, input logic [3:0] wy1,
    input logic m, input logic [3:0] fx, input logic [3:0] fy,
    input logic [3:0] ex, input logic [3:0] ey, input logic [5:0] ecnt,
    input int lat, input bit track
  );
    expT e;
    @(posedge clk);
    #1;
    winX0 = wx0; winY0 = wy0; winX1 = wx1; winY1 = wy1;
    mode = m; fixX = fx; fixY = fy;
    start = 1'b1;
    doneMark = doneCount;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (track) begin
      e.x = ex; e.y = ey; e.cnt = ecnt; e.lat = lat;
      e.startCycle = cycleCnt - 1;
      expQ.push_back(e);
    end
  endtask

  task automatic waitDone(input string name, input logic [3:0] ex, input logic [3:0] ey,
                          input logic [5:0] ecnt, input int lat);
    expT drop;
    int budget;
    budget = lat + 20;
    while (doneCount == doneMark && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    checkOutput({name, "_done_seen"}, doneCount - doneMark, 1);
    if (doneCount == doneMark && expQ.size() > 0) drop = expQ.pop_front();
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, "_hold_x"}, bestX, ex);
    checkOutput({name, "_hold_y"}, bestY, ey);
    checkOutput({name, "_hold_cnt"}, bestCnt, ecnt);
    checkOutput({name, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got sim time %0t, expected completion earlier", $time);
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rstN = 1'b0; start = 1'b0;
    winX0 = 0; winY0 = 0; winX1 = 0; winY1 = 0;
    mode = 0; fixX = 0; fixY = 0;
    fillPoints(4'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_best_x", bestX, 0);
    checkOutput("reset_best_y", bestY, 0);
    checkOutput("reset_best_cnt", bestCnt, 0);
    checkOutput("reset_pt_idx", ptIdx, 0);
    @(negedge clk) rstN = 1'b1;

    $display("[TB] boundary: dx=4 covered");
    fillPoints(4'd8, 4'd4);
    applyStimulus(4, 4, 4, 4, 0, 0, 0, 4, 4, 40, 44, 1);
    waitDone("edge_in", 4, 4, 40, 44);

    $display("[TB] boundary: distance 18 not covered");
    fillPoints(4'd7, 4'd7);
    applyStimulus(4, 4, 4, 4, 0, 0, 0, 4, 4, 0, 44, 1);
    waitDone("edge_out", 4, 4, 0, 44);

    $display("[TB] inverted window collapses to start");
    fillPoints(4'd6, 4'd6);
    applyStimulus(6, 2, 3, 1, 0, 0, 0, 6, 2, 40, 44, 1);
    waitDone("inverted", 6, 2, 40, 44);

    $display("[TB] mode 0 versus mode 1 with fixed circle");
    fillSplit(4'd1, 4'd1, 4'd14, 4'd14);
    applyStimulus(1, 1, 1, 1, 0, 14, 14, 1, 1, 20, 44, 1);
    waitDone("mode0", 1, 1, 20, 44);
    applyStimulus(1, 1, 1, 1, 1, 14, 14, 1, 1, 40, 44, 1);
    waitDone("mode1", 1, 1, 40, 44);

    $display("[TB] union tie rule");
    fillPoints(4'd2, 4'd2);
    applyStimulus(10, 10, 12, 12, 1, 2, 2, 10, 10, 40, 380, 1);
    waitDone("union", 10, 10, 40, 380);

    $display("[TB] latency, index sequence, ignored START");
    fillPoints(4'd3, 4'd3);
    applyStimulus(3, 3, 3, 3, 0, 0, 0, 3, 3, 40, 44, 1);
    for (int k = 1; k <= 43; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      start = (k == 20);
      @(negedge clk);
      checkOutput($sformatf("pt_idx_c%0d", k), ptIdx, (k >= 2 && k <= 41) ? k - 2 : 0);
    end
    start = 1'b0;
    waitDone("latency", 3, 3, 40, 44);

    $display("[TB] full-grid scan");
    fillPoints(4'd5, 4'd5);
    applyStimulus(0, 0, 15, 15, 0, 0, 0, 5, 1, 40, 10754, 1);
    waitDone("full", 5, 1, 40, 10754);

    $display("[TB] reset mid-scan");
    fillPoints(4'd1, 4'd1);
    applyStimulus(0, 0, 15, 15, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (99) @(posedge clk);
    #2;
    checkOutput("pre_reset_best_cnt", bestCnt, 40);
    rstN = 1'b0;
    #1;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    checkOutput("midrst_best_x", bestX, 0);
    checkOutput("midrst_best_y", bestY, 0);
    checkOutput("midrst_best_cnt", bestCnt, 0);
    checkOutput("midrst_pt_idx", ptIdx, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("no_done_after_reset", doneCount - doneMark, 0);

    fillPoints(4'd1, 4'd0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 40, 86, 1);
    waitDone("post_reset", 0, 0, 40, 86);

    $display("[TB] split population");
    fillSplit(4'd0, 4'd0, 4'd15, 4'd15);
    applyStimulus(0, 0, 15, 15, 0, 0, 0, 0, 0, 20, 10754, 1);
    waitDone("split", 0, 0, 20, 10754);

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cover_scan_sched.md
# cover_scan_sched

Scan scheduler for the two-circle laser coverage flow. It walks a rectangular window of candidate centres in raster order. For each candidate it issues all stored point indices to the shared point memory and counts the points covered by a radius-4 circle, optionally unioned with a fixed circle. It reports the first candidate with the highest count. The top-level controller invokes it once per optimisation pass: a full-grid scan for circle 1, a full-grid scan for circle 2, then local-window refinement passes.

## Interface
- NPTS, 40: number of stored points, indices 0..NPTS-1.
- R2, 16: squared radius; a point is covered when dx²+dy² <= R2.
- CLK in 1: clock, rising edge.
- RST_N in 1: reset, asynchronous, active-low; one clock domain only.
- START in 1: one-cycle request, sampled only in IDLE.
- WIN_X0, WIN_Y0, WIN_X1, WIN_Y1 in 4 each: inclusive scan window, latched on START.
- MODE in 1: 0 counts the candidate circle alone; 1 counts the union with the fixed circle. Latched on START.
- FIX_X, FIX_Y in 4 each: fixed-circle centre, latched on START.
- PT_IDX out 6: point-memory read index.
- PT_X, PT_Y in 4 each: point coordinates, valid one cycle after PT_IDX (registered read).
- BUSY out 1: high from the cycle after START acceptance until DONE.
- DONE out 1: one-cycle pulse when the result is valid.
- BEST_X, BEST_Y out 4 each: best centre; hold until the next accepted START.
- BEST_CNT out 6: covered-point count of the best centre.

## Operation
- FSM states: IDLE, INIT, SCAN, DRAIN, CMP, FIN.
  - IDLE→INIT on START. Latch the window, MODE, FIX_X and FIX_Y. START in any other state is ignored.
  - INIT:
    - Set the candidate (cx,cy) = (X0,Y0).
    - Set BEST = (X0,Y0), BEST_CNT = 0, acc = 0, idx = 0.
    - If X1<X0, treat X1 as X0. If Y1<Y0, treat Y1 as Y0.
    - Go to SCAN.
  - SCAN: drive PT_IDX = idx and increment idx. Leave after issuing idx NPTS-1 (NPTS cycles), going to DRAIN.
  - DRAIN: one cycle that consumes the last returned point. Go to CMP.
  - CMP:
    - If acc > BEST_CNT (strictly greater), replace BEST with (cx,cy, acc).
    - Clear acc and idx.
    - If (cx,cy) = (X1,Y1), go to FIN.
    - Else if cx = X1, set cx = X0, increment cy, go to SCAN.
    - Else increment cx, go to SCAN.
  - FIN: DONE = 1, BUSY = 0, go to IDLE.
- Coverage evaluation, in the cycle after each issue (SCAN cycles 2..NPTS and DRAIN):
  - dx = |PT_X-cx| and dy = |PT_Y-cy|, computed as 4-bit unsigned.
  - dx²+dy² is computed in 9 bits with no overflow (max 450).
  - In MODE 1, the same test is applied against (FIX_X,FIX_Y) and the two results are ORed.
  - acc increments when the point is covered. acc is 6 bits and cannot exceed NPTS.
- Tie rule: the earliest candidate in raster order (y-major, then x) wins.
- PT_IDX drives 0 outside SCAN.

## Timing
- Reset values: BUSY=0, DONE=0, BEST_X=0, BEST_Y=0, BEST_CNT=0, PT_IDX=0. FSM in IDLE.
- Per candidate: exactly NPTS+2 cycles (SCAN NPTS, DRAIN 1, CMP 1).
- N = (X1-X0+1)·(Y1-Y0+1). DONE is high in the cycle 2+N·(NPTS+2) cycles after the START-sampling edge, which is 44 cycles for N=1.
- BUSY is high for INIT through the final CMP, and low in FIN.
- START and DONE may coincide only with FIN→IDLE; such a START is ignored. The next START must arrive in IDLE.
- Reset asserted mid-scan: immediate return to IDLE and reset values. No DONE pulse; the partial result is discarded.
- Window at the grid edge (X1=15): cx increments are bounded by the X1 compare, so there is no 4-bit wrap.

## Test plan
- Boundary: all 40 points at (8,4), window (4,4)-(4,4), MODE 0 -> BEST_CNT=40 (dx=4, dy=0 is covered). Repeat with points at (7,7) -> BEST_CNT=0 (18>16).
- Full scan: all points at (5,5), window (0,0)-(15,15), MODE 0 -> BEST=(5,1), BEST_CNT=40. DONE at cycle 2+256·42 = 10754.
- Union mode: all points at (2,2), FIX=(2,2), window (10,10)-(12,12), MODE 1 -> BEST=(10,10) with cnt 40 (tie rule).
- Latency and handshake:
  - Window (3,3)-(3,3) -> BUSY high for 43 cycles, single DONE pulse at cycle 44.
  - PT_IDX sequence 0..39 is contiguous.
  - A START pulse at cycle 20 is ignored.
- Reset: assert RST_N=0 at cycle 100 of a full scan -> outputs zero asynchronously and no DONE. A fresh START after release completes normally.
- Split population: 20 points at (0,0) and 20 at (15,15), window (0,0)-(15,15), MODE 0 -> BEST=(0,0), BEST_CNT=20.
